sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (32-bit data, 10-bit address, `we`, registered `q`) between N_REQ requesters.
- Accepts at most one access per cycle over a valid/ready handshake and drives the RAM port.
- Routes registered read data back to the issuing requester.
- Sits between fabric-side masters and the sp_ram instance.

Parameters:
- DW, 32, data width (matches RAM data/q).
- AW, 10, address width; RAM depth is 2**AW.
- N_REQ, 2, number of requesters; legal range 2..4.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester access request.
- req_ready  out  N_REQ  one-hot grant; handshake when valid & ready.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data.
- resp_valid  out  N_REQ  one-hot read-response strobe.
- resp_rdata  out  DW  read data, shared by all requesters, qualified by resp_valid.
- ram_addr  out  AW  to RAM addr.
- ram_data  out  DW  to RAM data.
- ram_we  out  1  to RAM we.
- ram_q  in  DW  from RAM q; valid one cycle after the address is sampled.
- init_done  out  1  high once the arbiter accepts requests.

Behaviour:
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_rdata = 0.
  - ram_we = 0, ram_addr = 0, ram_data = 0.
  - rr_ptr = 0, pipeline tags cleared.
  - init_done = 0 if SP_RAM_ARB_INIT_EN is defined, else 1.
- FSM states: INIT, ARB.
  - Reset enters INIT when the macro is defined, otherwise ARB.
  - INIT moves to ARB after the last clear write; ARB is terminal until reset.
- Arbitration (ARB only):
  - Each cycle, search req_valid starting at index (rr_ptr+1) mod N_REQ.
  - The first valid index g gets req_ready[g] = 1, driven combinationally from req_valid and rr_ptr.
  - req_ready is 0 for all requesters in INIT.
  - On handshake, rr_ptr <= g. With no request, rr_ptr holds.
  - A requester holding valid is granted within N_REQ cycles; there is no starvation.
- RAM drive:
  - Outputs are registered: on a handshake edge, ram_addr/ram_data/ram_we load from the granted requester.
  - Otherwise ram_we <= 0, and ram_addr/ram_data hold.
  - The RAM samples these outputs on the following edge.
- Read latency, from handshake edge T:
  - RAM samples at T+1.
  - ram_q is valid after T+1.
  - resp_rdata <= ram_q and resp_valid[g] <= 1 at edge T+2, high for exactly one cycle.
  - Reads give 2 cycles handshake-to-response, fully pipelined at 1 access/cycle.
  - A two-stage tag pipeline ({valid, is_read, id}) carries g.
- Writes complete on handshake and produce no response.
- Read-after-write to the same address on back-to-back cycles returns the new data, because the write reaches the RAM one cycle earlier.
- Simultaneous valid from all requesters: exactly one grant per cycle, rotating in order.
- req_valid deasserting without ready: no side effect, nothing is latched.
- Reset mid-operation: in-flight reads are discarded and resp_valid is forced to 0 asynchronously. An INIT sweep restarts from address 0.

Optional Feature:
- Macro: SP_RAM_ARB_INIT_EN.
- Defined:
  - After reset, the FSM stays in INIT and writes 0 to every address 0..2**AW-1, one per cycle (ram_we = 1, incrementing AW-bit counter).
  - It then enters ARB and sets init_done = 1 on the cycle after the final write is driven.
  - Total 2**AW + 1 cycles after reset release.
- Undefined: INIT state and counter are absent; ARB is entered directly and init_done is tied 1.

Decomposition:
- Package sp_ram_arb_pkg holds:
  - state_e enum (INIT, ARB);
  - tag_t struct (valid, is_read, id[1:0]);
  - localparam ID_W = 2.
- One natural sub-module: sp_ram_rr_pick, a combinational round-robin picker (valid vector + pointer -> one-hot grant + index).

Test Plan:
- Init (macro on, AW=10): release rst_n, hold req_valid = 0 -> init_done rises 1025 cycles later; then read address 5 -> resp_rdata = 0.
- Single write/read, requester 0: write 0xDEADBEEF to address 0x3A, then read 0x3A -> resp_valid[0] exactly 2 cycles after the read handshake, resp_rdata = 0xDEADBEEF, resp_valid[1] = 0.
- Contention: both requesters hold valid reads for 6 cycles, rr_ptr = 0 after reset -> grants 1,0,1,0,1,0; responses 2 cycles behind each grant, on matching resp_valid bits.
- Back-to-back RAW: requester 1 writes 0x12345678 to address 7, then the next cycle reads 7 -> resp_rdata = 0x12345678.
- Sweep: write address i with $random for i = 0..31, then read 0..31 -> all 32 responses match the written values, 0 mismatches.
- Reset mid-read: assert rst_n low one cycle after a read handshake -> resp_valid stays 0, ram_we = 0, no response ever emitted for that read.

Source files
------------

// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM state encoding and read-tag layout.
// No logic and no latency of its own; holds the definitions used by the arbiter top.
// Backpressure: not applicable.
package sp_ram_arb_pkg;

    localparam int ID_W = 2;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_e;

    typedef struct packed {
        logic            valid;
        logic            is_read;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/sp_ram_rr_pick.sv
// Round-robin picker: first set bit of vld searching upward from ptr+1, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own enable.
module sp_ram_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  vld,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    // Step the candidate index with explicit wrap so non-power-of-two N stays in range.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N; k++) begin
            cand = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
            if (!any && vld[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin sharing of one single-port sync RAM; SP_RAM_ARB_INIT_EN adds a zero-fill sweep.
// Latency: read data 2 cycles after handshake, writes retire at handshake, 1 access/cycle.
// Backpressure: at most one req_ready per cycle; all ready held low during the init sweep.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*DW-1:0]   req_wdata,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [DW-1:0]         resp_rdata,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_data,
    output logic                  ram_we,
    input  logic [DW-1:0]         ram_q,
    output logic                  init_done
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gidx;
    logic [N_REQ-1:0] gnt;
    logic             any_vld;
    logic             arb_en;
    logic             hs;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic [N_REQ-1:0] resp_nxt;
    tag_t             tag0;
    tag_t             tag1;

    sp_ram_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .vld (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any_vld)
    );

`ifdef SP_RAM_ARB_INIT_EN
    state_e        state;
    logic [AW-1:0] init_cnt;
    logic          init_last;

    assign arb_en = (state == ARB);

    // init_last delays the ARB transition one cycle so the last clear write lands first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= '0;
            init_last <= 1'b0;
        end else if (state == INIT) begin
            if (init_last) begin
                state <= ARB;
            end else begin
                init_cnt  <= init_cnt + 1'b1;
                init_last <= (init_cnt == '1);
            end
        end
    end
`else
    assign arb_en = 1'b1;
`endif

    assign init_done = arb_en;
    assign req_ready = arb_en ? gnt : '0;
    assign hs        = arb_en & any_vld;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_we   = req_we[i];
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if (hs) begin
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_data <= sel_data;
        end
`ifdef SP_RAM_ARB_INIT_EN
        else if (!arb_en) begin
            ram_we   <= !init_last;
            ram_addr <= init_cnt;
            ram_data <= '0;
        end
`endif
        else begin
            ram_we <= 1'b0;
        end
    end

    always_comb begin
        resp_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_nxt[i] = tag1.valid & tag1.is_read & (tag1.id == ID_W'(i));
        end
    end

    // tag0 tracks the access the RAM samples next edge; tag1 the one whose q is now valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag0       <= '0;
            tag1       <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            rr_ptr     <= '0;
        end else begin
            tag0.valid   <= hs;
            tag0.is_read <= hs & ~sel_we;
            tag0.id      <= ID_W'(gidx);
            tag1         <= tag0;
            resp_valid   <= resp_nxt;
            if (|resp_nxt) begin
                resp_rdata <= ram_q;
            end
            if (hs) begin
                rr_ptr <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural sync RAM; covers both SP_RAM_ARB_INIT_EN builds.
module tb_sp_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NR = 2;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_data;
    logic               ram_we;
    logic [DW-1:0]      ram_q;
    logic               init_done;

    sp_ram_arbiter #(.DW(DW), .AW(AW), .N_REQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-before-write, registered q.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NR-1:0] vec;
        logic [DW-1:0] dat;
    } rsp_t;
    rsp_t rsp_q[$];

    always @(negedge clk) begin
        if (resp_valid != '0) rsp_q.push_back('{cyc: cyc, vec: resp_valid, dat: resp_rdata});
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge following the handshake edge.
    task automatic xfer(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int hs);
        logic g;
        req_valid[r]           = 1'b1;
        req_we[r]              = we;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
        hs = -1;
        for (int n = 0; n < 16 && hs < 0; n++) begin
            #1 g = req_ready[r];
            @(posedge clk);
            #1;
            if (g) hs = cyc;
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        chk("grant_seen", (hs >= 0), 1);
    endtask

    task automatic get_rsp(input string tag, input int exp_cyc, input logic [NR-1:0] exp_vec,
                           input logic [DW-1:0] exp_dat);
        rsp_t r;
        int   n;
        n = 0;
        while (rsp_q.size() == 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rsp_q.size() == 0) begin
            chk({tag, "_present"}, rsp_q.size(), 1);
        end else begin
            r = rsp_q.pop_front();
            chk({tag, "_lat"}, r.cyc, exp_cyc);
            chk({tag, "_vec"}, r.vec, exp_vec);
            chk({tag, "_dat"}, r.dat, exp_dat);
        end
    endtask

    initial begin
        int hs, hs2, t0, n;
        logic [DW-1:0] sweep [0:31];
        rsp_t r;

        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
`ifdef SP_RAM_ARB_INIT_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif

        // Init sweep length, then read a cleared location
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
`ifdef SP_RAM_ARB_INIT_EN
        chk("init_cycles", n, 1025);
`else
        chk("init_cycles", n, 0);
`endif
        @(negedge clk);
        xfer(0, 1'b0, 10'd5, '0, hs);
        get_rsp("init_rd5", hs + 2, 2'b01, 32'h0);

        // Single write then read, requester 0
        @(negedge clk);
        xfer(0, 1'b1, 10'h3A, 32'hDEADBEEF, hs);
        xfer(0, 1'b0, 10'h3A, '0, hs);
        get_rsp("wr_rd", hs + 2, 2'b01, 32'hDEADBEEF);

        // Contention: rr_ptr is 0, so grants alternate starting at requester 1
        @(negedge clk);
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {10'd5, 10'h3A};
        t0 = 0;
        for (int k = 0; k < 6; k++) begin
            #1 chk("ct_grant", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            if (k == 0) t0 = cyc;
            @(negedge clk);
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        chk("ct_rsp_count", rsp_q.size(), 6);
        for (int k = 0; k < 6 && rsp_q.size() > 0; k++) begin
            r = rsp_q.pop_front();
            chk("ct_lat", r.cyc, t0 + k + 2);
            chk("ct_vec", r.vec, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("ct_dat", r.dat, (k % 2 == 0) ? 32'h0 : 32'hDEADBEEF);
        end

        // Back-to-back read-after-write, requester 1
        @(negedge clk);
        xfer(1, 1'b1, 10'd7, 32'h12345678, hs);
        xfer(1, 1'b0, 10'd7, '0, hs2);
        chk("raw_b2b", hs2, hs + 1);
        get_rsp("raw", hs2 + 2, 2'b10, 32'h12345678);

        // Sweep of 32 random words
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            sweep[i] = $urandom;
            xfer(0, 1'b1, AW'(i), sweep[i], hs);
        end
        for (int i = 0; i < 32; i++) begin
            xfer(0, 1'b0, AW'(i), '0, hs);
            get_rsp("sweep", hs + 2, 2'b01, sweep[i]);
        end

        // Reset one cycle after a read handshake drops the pending response
        @(negedge clk);
        xfer(0, 1'b0, 10'h3A, '0, hs);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_rvalid", resp_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_rst_hold", resp_valid, 0);
        end
        rst_n = 1'b1;
`ifdef SP_RAM_ARB_INIT_EN
        @(negedge clk);
        chk("reinit_addr", ram_addr, 0);
        chk("reinit_we", ram_we, 1);
`endif
        n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reinit_done", init_done, 1);
        repeat (4) @(negedge clk);
        chk("no_stray_rsp", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
